// File: rtl/sentinel_pkg.sv
// sentinel_pkg: shared key constant, FSM state type and 7-segment patterns for the Sentinel key path and gate.
package sentinel_pkg;
  localparam logic [7:0] VAELIX_KEY = 8'hB6;
  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_RELEASE, LOCKOUT} state_t;
  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_O     = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_N     = 7'h54;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
endpackage

// File: rtl/sentinel_debounce.sv
// sentinel_debounce: 2-flop synchroniser plus stability counter for one bouncy asynchronous input.
module sentinel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else sync <= {sync[0], raw};
  end
  // The counter restarts on every flip, so it never climbs past DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      db <= 1'b0;
    end else if (ena) begin
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sentinel_key_conditioner.sv
// sentinel_key_conditioner: syncs the DIP key, debounces submit, captures the key and tracks failed attempts.
// Fail counter, LOCKOUT state and lockout timer exist only when SENTINEL_LOCKOUT_EN is defined.
module sentinel_key_conditioner
  import sentinel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] key_raw,
  input  logic       submit_raw,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       match,
  output logic       locked_out,
  output logic [1:0] fail_count
);
  if (DEBOUNCE_CYCLES < 1 || MAX_FAIL < 1 || MAX_FAIL > 3 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("sentinel_key_conditioner: parameter out of range");
  end
  logic [7:0] k1, key_sync;
  logic submit_db;
  state_t state, state_n;
  logic [7:0] key_q, key_q_n;
  logic valid_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {key_sync, k1} <= '0;
    else {key_sync, k1} <= {k1, key_raw};
  end
  sentinel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .raw(submit_raw),
    .db(submit_db)
  );
`ifdef SENTINEL_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [1:0] fails, fails_n, fails_inc;
  assign fails_inc = fails + 2'd1;
  assign fail_count = fails;
  assign locked_out = state == LOCKOUT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fails <= '0;
      lock_cnt <= '0;
    end else if (ena) begin
      fails <= fails_n;
      lock_cnt <= lock_cnt_n;
    end
  end
`else
  assign fail_count = 2'd0;
  assign locked_out = 1'b0;
`endif
  always_comb begin
    state_n = state;
    key_q_n = key_q;
    valid_n = 1'b0;
`ifdef SENTINEL_LOCKOUT_EN
    fails_n = fails;
    lock_cnt_n = lock_cnt;
`endif
    case (state)
      IDLE: if (submit_db) begin
        key_q_n = key_sync;
        valid_n = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: begin
        state_n = WAIT_RELEASE;
`ifdef SENTINEL_LOCKOUT_EN
        fails_n = match ? 2'd0 : fails_inc;
        if (!match && fails_inc == 2'(MAX_FAIL)) begin
          state_n = LOCKOUT;
          key_q_n = '0;
        end
`endif
      end
      WAIT_RELEASE: if (!submit_db) state_n = IDLE;
`ifdef SENTINEL_LOCKOUT_EN
      LOCKOUT: begin
        lock_cnt_n = lock_cnt + 1'b1;
        if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
          lock_cnt_n = '0;
          fails_n = '0;
          state_n = WAIT_RELEASE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // match is registered alongside key_q so CAPTURE can act on it without a compare path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key_q <= '0;
      match <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= ena & valid_n;
      if (ena) begin
        state <= state_n;
        key_q <= key_q_n;
        match <= key_q_n == VAELIX_KEY;
      end
    end
  end
  assign key_out = key_q;
endmodule

// File: tb/tb_sentinel_key_conditioner.sv
// tb_sentinel_key_conditioner: directed test-plan scenarios plus randomized traffic against a cycle reference model.
module tb_sentinel_key_conditioner;
  localparam int DB = 4;
  localparam int MF = 3;
  localparam int LC = 8;
`ifdef SENTINEL_LOCKOUT_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  localparam int READY = 0, TAKEN = 1, HOLD = 2, LOCKED = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic submit_raw = 1'b0;
  logic [7:0] key_raw = 8'h00;
  logic [7:0] key_out;
  logic key_valid, match, locked_out;
  logic [1:0] fail_count;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m_k1 = 0, m_k2 = 0, m_held = 0;
  logic m_s1 = 0, m_s2 = 0, m_db = 0, m_valid = 0;
  int m_run = 0, m_phase = READY, m_fails = 0, m_left = 0;

  always #5 clk = ~clk;

  sentinel_key_conditioner #(.DEBOUNCE_CYCLES(DB), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .key_raw(key_raw),
    .submit_raw(submit_raw),
    .key_out(key_out),
    .key_valid(key_valid),
    .match(match),
    .locked_out(locked_out),
    .fail_count(fail_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen two edges late, level accepted after DB differing samples, one press one capture.
  task automatic model_step();
    if (rst) begin
      {m_k1, m_k2, m_held} = '0;
      {m_s1, m_s2, m_db, m_valid} = '0;
      m_run = 0; m_phase = READY; m_fails = 0; m_left = 0;
    end else begin
      m_valid = 1'b0;
      if (ena) begin
        case (m_phase)
          READY: if (m_db) begin m_held = m_k2; m_valid = 1'b1; m_phase = TAKEN; end
          TAKEN: begin
            if (m_held == 8'hB6) m_fails = 0;
            else if (LK) m_fails = m_fails + 1;
            m_phase = HOLD;
            if (LK && m_fails == MF) begin m_phase = LOCKED; m_held = 8'h00; m_left = LC; end
          end
          HOLD: if (!m_db) m_phase = READY;
          default: begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_fails = 0; m_phase = HOLD; end
          end
        endcase
        if (m_s2 != m_db) begin
          m_run = m_run + 1;
          if (m_run == DB) begin m_db = m_s2; m_run = 0; end
        end else m_run = 0;
      end
      m_k2 = m_k1; m_k1 = key_raw;
      m_s2 = m_s1; m_s1 = submit_raw;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("key_out", key_out, m_held);
      check("key_valid", key_valid, m_valid);
      check("match", match, m_held == 8'hB6);
      check("locked_out", locked_out, m_phase == LOCKED);
      check("fail_count", fail_count, m_fails);
    end
  end

  task automatic press(input logic [7:0] k, output int lat);
    key_raw = k;
    submit_raw = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (key_valid) lat = i;
    end
  endtask

  task automatic release_btn();
    submit_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(key_valid);
    end
  endtask

  initial begin
    int lat, cnt, vcnt, lk, hold;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_key_out", key_out, 8'h00);
    check("rst_key_valid", key_valid, 0);
    check("rst_match", match, 0);
    check("rst_locked", locked_out, 0);
    check("rst_fail", fail_count, 0);
    press(8'hB6, lat);
    check("ok_latency", lat, 7);
    check("ok_key", key_out, 8'hB6);
    check("ok_match", match, 1);
    count_valid(20, vcnt);
    check("held_no_repeat", vcnt, 0);
    release_btn();
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      submit_raw = i[1];
      @(negedge clk);
      vcnt += int'(key_valid);
    end
    submit_raw = 1'b0;
    count_valid(10, cnt);
    check("bounce_no_valid", vcnt + cnt, 0);
    press(8'hB6, lat);
    check("clean_latency", lat, 7);
    check("clean_key", key_out, 8'hB6);
    release_btn();
    for (int p = 1; p <= 3; p++) begin
      press(8'h12, lat);
      check("bad_latency", lat, 7);
      check("bad_key", key_out, 8'h12);
      @(negedge clk);
      check("bad_fail_count", fail_count, LK ? p : 0);
      if (p < 3) release_btn();
    end
    check("lock_entry", locked_out, LK);
    check("lock_entry_key", key_out, LK ? 8'h00 : 8'h12);
    lk = int'(locked_out);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      key_raw = 8'hB6;
      submit_raw = i < 12;
      @(negedge clk);
      lk += int'(locked_out);
      vcnt += int'(key_valid);
      if (locked_out) check("lock_key_zero", key_out, 8'h00);
    end
    check("lock_length", lk, LK ? LC : 0);
    check("lock_no_valid", vcnt, 0);
    check("lock_fail_cleared", fail_count, 0);
    press(8'h12, lat);
    @(negedge clk);
    check("mix_fail1", fail_count, LK ? 1 : 0);
    release_btn();
    press(8'h34, lat);
    @(negedge clk);
    check("mix_fail2", fail_count, LK ? 2 : 0);
    release_btn();
    press(8'hB6, lat);
    @(negedge clk);
    check("mix_fail0", fail_count, 0);
    check("mix_no_lock", locked_out, 0);
    check("mix_match", match, 1);
    release_btn();
    for (int p = 1; p <= 3; p++) begin
      press(8'h12, lat);
      @(negedge clk);
      if (p < 3) release_btn();
    end
    submit_raw = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", locked_out, 0);
    check("arst_key", key_out, 8'h00);
    check("arst_fail", fail_count, 0);
    check("arst_match", match, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(8'hB6, lat);
    check("post_rst_latency", lat, 7);
    check("post_rst_key", key_out, 8'hB6);
    release_btn();
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        submit_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) key_raw = $urandom_range(0, 1) != 0 ? 8'hB6 : 8'($urandom);
      ena = $urandom_range(0, 9) != 0;
      @(negedge clk);
    end
    ena = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
